// File: rtl/fpu_pkg.sv
// Shared single-precision FPU definitions.
//   FP_EXP_MAX / FP_QNAN / FP_INF : IEEE-754 single-precision constants
//   FLG_*                          : bit positions inside the 4-bit class flag vector
//   div_state_e                    : divider issue FSM states
//   fp_class()                     : 32-bit IEEE single -> {nan, inf, zero, subnormal}
package fpu_pkg;

    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] FP_INF     = 32'h7F80_0000;

    localparam int unsigned FLG_NAN  = 3;
    localparam int unsigned FLG_INF  = 2;
    localparam int unsigned FLG_ZERO = 1;
    localparam int unsigned FLG_SUB  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } div_state_e;

    function automatic logic [3:0] fp_class(input logic [31:0] v);
        logic [7:0]  e;
        logic [22:0] m;
        logic [3:0]  f;
        e           = v[30:23];
        m           = v[22:0];
        f           = '0;
        f[FLG_NAN]  = (e == FP_EXP_MAX) && (m != '0);
        f[FLG_INF]  = (e == FP_EXP_MAX) && (m == '0);
        f[FLG_ZERO] = (e == '0) && (m == '0);
        f[FLG_SUB]  = (e == '0) && (m != '0);
        return f;
    endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// Synchronous request FIFO, DEPTH entries of WIDTH bits, first-word fall-through read.
//   clk, rst_n : clock, asynchronous active-low reset (pointers and count only)
//   push, din  : write request; ignored while full
//   pop, dout  : read request; dout always shows the head entry; ignored while empty
//   full/empty : status
//   count      : number of stored entries, 0..DEPTH
module fpu_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 68
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fpu_sp_div_issue.sv
// Request front-end for the single-precision divider.
// Queues tagged operand pairs, issues one at a time to the divider and holds the
// result, tag and class flags in a single response slot until consumed.
//   req_*   : valid/ready request port (req_ready = !full)
//   resp_*  : valid/ready response port with result, tag and {nan,inf,zero,sub}
//   div_*   : divider operand/strobe outputs and result/ready inputs
//   busy    : queue non-empty, operation in progress, or response pending
//   occupancy : queue entry count
module fpu_sp_div_issue
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_a,
    input  logic [31:0]              req_b,
    input  logic [TAG_W-1:0]         req_tag,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_result,
    output logic [TAG_W-1:0]         resp_tag,
    output logic [3:0]               resp_flags,
    output logic [31:0]              div_din1,
    output logic [31:0]              div_din2,
    output logic                     div_dval,
    input  logic [31:0]              div_result,
    input  logic                     div_rdy,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned ENTRY_W = 64 + TAG_W;

    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;
    logic [TAG_W-1:0]   inflight_tag;
    logic               start_issue;
    div_state_e         state;

    assign wr_entry  = {req_tag, req_a, req_b};
    assign req_ready = !full;
    assign push      = req_valid && !full;

    // Issue is decided in IDLE and its registered outputs are loaded on the same
    // edge, so ISSUE is exactly the one cycle div_dval is high. Waiting for an
    // empty response slot guarantees div_rdy never finds it occupied.
    assign start_issue = (state == IDLE) && !empty && !resp_valid;
    assign pop         = start_issue;

    assign busy = !empty || (state != IDLE) || resp_valid;

    fpu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (wr_entry),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            div_dval     <= 1'b0;
            div_din1     <= '0;
            div_din2     <= '0;
            inflight_tag <= '0;
            resp_valid   <= 1'b0;
            resp_result  <= '0;
            resp_tag     <= '0;
            resp_flags   <= '0;
        end else begin
            div_dval <= 1'b0;
            if (resp_valid && resp_ready) resp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_issue) begin
                        div_din1     <= head[63:32];
                        div_din2     <= head[31:0];
                        div_dval     <= 1'b1;
                        inflight_tag <= head[ENTRY_W-1 -: TAG_W];
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (div_rdy) begin
                        resp_result <= div_result;
                        resp_tag    <= inflight_tag;
                        resp_flags  <= fp_class(div_result);
                        resp_valid  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_sp_div_issue.sv
module tb_fpu_sp_div_issue;
    import fpu_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned DIV_LAT = 6;

    logic               clk;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [31:0]        req_a;
    logic [31:0]        req_b;
    logic [TAG_W-1:0]   req_tag;
    logic               resp_valid;
    logic               resp_ready;
    logic [31:0]        resp_result;
    logic [TAG_W-1:0]   resp_tag;
    logic [3:0]         resp_flags;
    logic [31:0]        div_din1;
    logic [31:0]        div_din2;
    logic               div_dval;
    logic [31:0]        div_result;
    logic               div_rdy;
    logic               inj_rdy;
    logic               div_rdy_dut;
    logic               busy;
    logic [$clog2(DEPTH):0] occupancy;

    assign div_rdy_dut = div_rdy | inj_rdy;

    fpu_sp_div_issue #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_tag     (req_tag),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_tag    (resp_tag),
        .resp_flags  (resp_flags),
        .div_din1    (div_din1),
        .div_din2    (div_din2),
        .div_dval    (div_dval),
        .div_result  (div_result),
        .div_rdy     (div_rdy_dut),
        .busy        (busy),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in divider: fixed latency, quotients for the operand pairs used here.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        if (b[30:0] == 31'h0)
            return (a[30:0] == 31'h0) ? FP_QNAN : (FP_INF | {a[31] ^ b[31], 31'h0});
        if (b == 32'h3F80_0000) return a;
        if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (a == 32'h0080_0000 && b == 32'h4000_0000) return 32'h0040_0000;
        return 32'hDEAD_BEEF;
    endfunction

    logic [31:0] op_a, op_b;
    int unsigned lat_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt    <= 0;
            div_rdy    <= 1'b0;
            div_result <= '0;
            op_a       <= '0;
            op_b       <= '0;
        end else begin
            div_rdy <= 1'b0;
            if (div_dval) begin
                op_a    <= div_din1;
                op_b    <= div_din2;
                lat_cnt <= DIV_LAT;
            end else if (lat_cnt != 0) begin
                lat_cnt <= lat_cnt - 1;
                if (lat_cnt == 1) begin
                    div_rdy    <= 1'b1;
                    div_result <= ref_div(op_a, op_b);
                end
            end
        end
    end

    // Strobe monitor: pulse count, pulses while an op is outstanding, pulses > 1 cycle.
    int   dval_cnt = 0;
    int   overlap_cnt = 0;
    int   long_cnt = 0;
    logic outstanding;
    logic dval_prev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= 1'b0;
            dval_prev   <= 1'b0;
        end else begin
            dval_prev <= div_dval;
            if (div_dval) begin
                dval_cnt <= dval_cnt + 1;
                if (outstanding) overlap_cnt <= overlap_cnt + 1;
                if (dval_prev)   long_cnt <= long_cnt + 1;
                outstanding <= 1'b1;
            end else if (div_rdy) begin
                outstanding <= 1'b0;
            end
        end
    end

    typedef struct packed {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        logic [3:0]       flags;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic reset_check(input string name);
        chk({name, "_req_ready"},   64'(req_ready),   64'(1));
        chk({name, "_resp_valid"},  64'(resp_valid),  64'(0));
        chk({name, "_resp_result"}, 64'(resp_result), 64'(0));
        chk({name, "_resp_tag"},    64'(resp_tag),    64'(0));
        chk({name, "_resp_flags"},  64'(resp_flags),  64'(0));
        chk({name, "_dval"},        64'(div_dval),    64'(0));
        chk({name, "_din1"},        64'(div_din1),    64'(0));
        chk({name, "_din2"},        64'(div_din2),    64'(0));
        chk({name, "_busy"},        64'(busy),        64'(0));
        chk({name, "_occupancy"},   64'(occupancy),   64'(0));
    endtask

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag,
                        input logic [31:0] res, input logic [3:0] fl);
        int unsigned n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("send_ready_timeout", 64'(req_ready), 64'(1));
            return;
        end
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        req_valid = 1'b1;
        @(posedge clk);
        sb.push_back('{res, tag, fl});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string name);
        exp_t        e;
        int unsigned n = 0;
        while (!resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) begin
            chk({name, "_timeout"}, 64'(resp_valid), 64'(1));
            return;
        end
        if (sb.size() == 0) begin
            chk({name, "_unexpected"}, 64'(sb.size()), 64'(1));
        end else begin
            e = sb.pop_front();
            chk({name, "_result"}, 64'(resp_result), 64'(e.res));
            chk({name, "_tag"},    64'(resp_tag),    64'(e.tag));
            chk({name, "_flags"},  64'(resp_flags),  64'(e.flags));
        end
        if (resp_ready) @(negedge clk);
    endtask

    initial begin
        int          d0;
        int          ov0;
        int          lg0;
        int          unstable;
        int          seen;
        int unsigned n;

        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_tag    = '0;
        resp_ready = 1'b1;
        inj_rdy    = 1'b0;
        #1 rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        reset_check("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // 6.0 / 2.0 with latency checks along the way
        d0 = dval_cnt;
        send(32'h40C0_0000, 32'h4000_0000, 4'd3, 32'h4040_0000, 4'b0000);
        chk("t1_occ_after_push", 64'(occupancy), 64'(1));
        chk("t1_dval_not_yet",   64'(div_dval),  64'(0));
        @(negedge clk);
        chk("t1_dval_high", 64'(div_dval),  64'(1));
        chk("t1_din1",      64'(div_din1),  64'(32'h40C0_0000));
        chk("t1_din2",      64'(div_din2),  64'(32'h4000_0000));
        chk("t1_occ_pop",   64'(occupancy), 64'(0));
        @(negedge clk);
        chk("t1_dval_low",  64'(div_dval),  64'(0));
        chk("t1_din1_hold", 64'(div_din1),  64'(32'h40C0_0000));
        n = 0;
        while (!div_rdy_dut && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t1_rdy_seen",  64'(div_rdy_dut), 64'(1));
        chk("t1_resp_pre",  64'(resp_valid),  64'(0));
        @(negedge clk);
        chk("t1_resp_rise", 64'(resp_valid),  64'(1));
        wait_resp("t1");
        chk("t1_one_dval", 64'(dval_cnt - d0), 64'(1));

        // a div_rdy with nothing in flight must not produce a response
        inj_rdy = 1'b1;
        @(negedge clk);
        inj_rdy = 1'b0;
        @(negedge clk);
        chk("stray_rdy_resp", 64'(resp_valid), 64'(0));
        chk("stray_rdy_busy", 64'(busy),       64'(0));

        // special-value classes
        send(32'h3F80_0000, 32'h0000_0000, 4'd1, 32'h7F80_0000, 4'b0100);
        wait_resp("t2_inf");
        send(32'h0000_0000, 32'h0000_0000, 4'd2, 32'h7FC0_0000, 4'b1000);
        wait_resp("t2_nan");
        send(32'h0080_0000, 32'h4000_0000, 4'd4, 32'h0040_0000, 4'b0001);
        wait_resp("t3_sub");

        // five back-to-back requests
        d0  = dval_cnt;
        ov0 = overlap_cnt;
        lg0 = long_cnt;
        send(32'h40A0_0000, 32'h3F80_0000, 4'd5, 32'h40A0_0000, 4'b0000);
        send(32'h4120_0000, 32'h3F80_0000, 4'd6, 32'h4120_0000, 4'b0000);
        send(32'h41A0_0000, 32'h3F80_0000, 4'd7, 32'h41A0_0000, 4'b0000);
        send(32'h42C8_0000, 32'h3F80_0000, 4'd8, 32'h42C8_0000, 4'b0000);
        send(32'h3E80_0000, 32'h3F80_0000, 4'd9, 32'h3E80_0000, 4'b0000);
        chk("t4_full_occ",   64'(occupancy), 64'(DEPTH));
        chk("t4_full_ready", 64'(req_ready), 64'(0));
        for (int i = 0; i < 5; i++) wait_resp("t4");
        chk("t4_dval_count", 64'(dval_cnt - d0),     64'(5));
        chk("t4_overlap",    64'(overlap_cnt - ov0), 64'(0));
        chk("t4_long_pulse", 64'(long_cnt - lg0),    64'(0));

        // back-pressure on the response slot
        resp_ready = 1'b0;
        send(32'h4100_0000, 32'h3F80_0000, 4'd10, 32'h4100_0000, 4'b0000);
        n = 0;
        while (!resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_first_valid", 64'(resp_valid), 64'(1));
        send(32'h4200_0000, 32'h3F80_0000, 4'd11, 32'h4200_0000, 4'b0000);
        d0       = dval_cnt;
        unstable = 0;
        repeat (300) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_result !== 32'h4100_0000 || resp_tag !== 4'd10)
                unstable++;
        end
        chk("t5_stable",   64'(unstable),       64'(0));
        chk("t5_no_dval",  64'(dval_cnt - d0),  64'(0));
        chk("t5_queued",   64'(occupancy),      64'(1));
        resp_ready = 1'b1;
        wait_resp("t5a");
        wait_resp("t5b");
        chk("t5_next_issued", 64'(dval_cnt - d0), 64'(1));

        // reset while the divider is working
        send(32'h40C0_0000, 32'h4000_0000, 4'd12, 32'h4040_0000, 4'b0000);
        repeat (3) @(negedge clk);
        chk("t6_in_wait_busy", 64'(busy),      64'(1));
        chk("t6_in_wait_resp", 64'(resp_valid), 64'(0));
        rst_n = 1'b0;
        #1;
        reset_check("t6_rst");
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (20) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("t6_no_stale", 64'(seen), 64'(0));
        send(32'h0000_0000, 32'h3F80_0000, 4'd6, 32'h0000_0000, 4'b0010);
        wait_resp("t6_after");
        chk("t6_idle_busy", 64'(busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
